// File: rtl/west_feeder_pkg.sv
// Shared definitions for the west-edge feeder of the MAC array:
// per-row instruction encodings, controller states and the mode-to-instruction mapping.
package west_feeder_pkg;

   localparam logic [1:0] INST_IDLE = 2'b00;
   localparam logic [1:0] INST_LOAD = 2'b01;
   localparam logic [1:0] INST_EXEC = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   // Burst mode 0 loads kernels, mode 1 executes.
   function automatic logic [1:0] mode_inst(input logic mode);
      return mode ? INST_EXEC : INST_LOAD;
   endfunction

endpackage

// File: rtl/west_feeder_if.sv
// Bus bundle between the buffer/command side and the feeder, plus the
// per-row outputs that go to the west edge of the MAC array.
interface west_feeder_if #(
   parameter int bw     = 4,
   parameter int row    = 8,
   parameter int len_bw = 8
);
   logic                wr;
   logic [row*bw-1:0]   in;
   logic                full;
   logic                empty;
   logic                wr_drop;
   logic                cmd_valid;
   logic                cmd_mode;
   logic [len_bw-1:0]   cmd_len;
   logic                cmd_ready;
   logic [row*bw-1:0]   out_w;
   logic [row*2-1:0]    inst_w;
   logic                busy;
   logic                done;

   modport master (
      output wr, in, cmd_valid, cmd_mode, cmd_len,
      input  full, empty, wr_drop, cmd_ready, out_w, inst_w, busy, done
   );

   modport slave (
      input  wr, in, cmd_valid, cmd_mode, cmd_len,
      output full, empty, wr_drop, cmd_ready, out_w, inst_w, busy, done
   );
endinterface

// File: rtl/west_feeder_skew_line.sv
// Fixed-latency delay line: an instruction+element lane delayed by depth cycles.
// Every stage clears on reset so bubbles (all zero) flush out immediately.
module skew_line #(
   parameter int width = 6,
   parameter int depth = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [width-1:0] d,
   output logic [width-1:0] q
);

   logic [width-1:0] stage [depth];

   // Shift the lane one stage per cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < depth; i++) stage[i] <= '0;
      end else begin
         stage[0] <= d;
         for (int i = 1; i < depth; i++) stage[i] <= stage[i-1];
      end
   end

   assign q = stage[depth-1];

endmodule

// File: rtl/west_feeder.sv
// Row-side transmitter: buffers row-vectors, issues bursts under command,
// and skews the issued stream so row r lags row 0 by r cycles.
module west_feeder
   import west_feeder_pkg::*;
#(
   parameter int bw     = 4,
   parameter int row    = 8,
   parameter int depth  = 64,
   parameter int len_bw = 8
) (
   input  logic         clk,
   input  logic         reset,
   west_feeder_if.slave bus
);

   localparam int ptr_bw = $clog2(depth);
   localparam int cnt_bw = ptr_bw + 1;
   localparam int dc_bw  = (row > 2) ? $clog2(row - 1) : 1;
   localparam logic [dc_bw-1:0] drain_last = dc_bw'((row > 1) ? row - 2 : 0);

   logic [row*bw-1:0] mem [depth];
   logic [ptr_bw-1:0] wr_ptr, rd_ptr;
   logic [cnt_bw-1:0] count;
   logic              drop_q;
   logic              push, pop;

   state_t            state;
   logic              mode_q;
   logic [len_bw-1:0] len_q, issued;
   logic [dc_bw-1:0]  drain_cnt;
   logic              done_q;

   logic [row*bw-1:0] issue_data;
   logic [1:0]        issue_inst;

   assign bus.full  = (count == cnt_bw'(depth));
   assign bus.empty = (count == '0);
   assign push      = bus.wr && !bus.full;
   assign pop       = (state == S_RUN) && !bus.empty;

   // Buffer storage write port.
   // NOTE: the data array is deliberately not reset; clearing pointers and count makes old contents unreachable.
   // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= bus.in;
   end

   // Pointers, occupancy and the sticky overflow flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         drop_q <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + ptr_bw'(1);
         if (pop)  rd_ptr <= rd_ptr + ptr_bw'(1);
         case ({push, pop})
            2'b10:   count <= count + cnt_bw'(1);
            2'b01:   count <= count - cnt_bw'(1);
            default: count <= count;
         endcase
         if (bus.wr && bus.full) drop_q <= 1'b1;
      end
   end

   // Select what enters the skew lines this cycle: popped vector or a bubble.
   // NOTE: defaults are assigned first so no path leaves an output unassigned (no latch).
   always_comb begin
      issue_data = '0;
      issue_inst = INST_IDLE;
      if (pop) begin
         issue_data = mem[rd_ptr];
         issue_inst = mode_inst(mode_q);
      end
   end

   // Burst controller: accept a command, issue len vectors, then flush the skew.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         mode_q    <= 1'b0;
         len_q     <= '0;
         issued    <= '0;
         drain_cnt <= '0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.cmd_valid) begin
                  mode_q    <= bus.cmd_mode;
                  len_q     <= bus.cmd_len;
                  issued    <= '0;
                  drain_cnt <= '0;
                  state     <= (bus.cmd_len != '0) ? S_RUN : S_DRAIN;
               end
            end
            S_RUN: begin
               if (pop) begin
                  issued <= issued + len_bw'(1);
                  if (issued + len_bw'(1) == len_q) begin
                     state     <= S_DRAIN;
                     drain_cnt <= '0;
                  end
               end
            end
            S_DRAIN: begin
               if (drain_cnt == drain_last) begin
                  state  <= S_IDLE;
                  done_q <= 1'b1;
               end else begin
                  drain_cnt <= drain_cnt + dc_bw'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.cmd_ready = (state == S_IDLE);
   assign bus.busy      = (state != S_IDLE);
   assign bus.done      = done_q;
   assign bus.wr_drop   = drop_q;

   // Row r gets r+1 register stages; instruction and element travel together.
   for (genvar r = 0; r < row; r++) begin : g_row
      logic [bw+1:0] lane_q;
      skew_line #(.width(bw + 2), .depth(r + 1)) u_skew (
         .clk   (clk),
         .reset (reset),
         .d     ({issue_inst, issue_data[r*bw +: bw]}),
         .q     (lane_q)
      );
      assign bus.out_w[r*bw +: bw] = lane_q[bw-1:0];
      assign bus.inst_w[2*r +: 2]  = lane_q[bw+1:bw];
   end

endmodule

// File: tb/tb_west_feeder.sv
// Bench for west_feeder: directed scenarios plus a random phase, all checked
// every cycle against a queue-based reference of the feeder's behaviour.
module tb_west_feeder;
   import west_feeder_pkg::*;

   localparam int BW = 4, ROW = 8, DEPTH = 64, LEN_BW = 8;
   localparam int W = ROW * BW;

   logic clk = 1'b0;
   logic reset = 1'b1;

   west_feeder_if #(.bw(BW), .row(ROW), .len_bw(LEN_BW)) bus ();

   west_feeder #(.bw(BW), .row(ROW), .depth(DEPTH), .len_bw(LEN_BW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0, cyc = 0;
   int done_hits = 0, load_hits = 0;

   // Reference: buffered vectors, and what was issued in each cycle.
   logic [W-1:0] fifo [$];
   logic [W-1:0] hist_data [int];
   logic [1:0]   hist_inst [int];
   typedef enum {PH_IDLE, PH_RUN, PH_DRAIN} phase_t;
   phase_t ph = PH_IDLE;
   bit m_mode = 0, m_drop = 0, m_done = 0;
   int m_left = 0, m_drain = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_reset();
      fifo.delete();
      hist_data.delete();
      hist_inst.delete();
      ph = PH_IDLE;
      m_drop = 0;
      m_done = 0;
   endtask

   // One clock cycle with the inputs currently driven, then compare everything.
   task automatic tick();
      int sz, c;
      bit pop, accept;
      logic [W-1:0] eo, hd;
      logic [2*ROW-1:0] ei;
      logic [1:0] hi;
      sz = fifo.size();
      pop = (ph == PH_RUN) && (sz > 0);
      accept = bus.wr && (sz < DEPTH);
      if (bus.wr && !accept) m_drop = 1;
      hist_data[cyc] = '0;
      hist_inst[cyc] = INST_IDLE;
      if (pop) begin
         hist_data[cyc] = fifo.pop_front();
         hist_inst[cyc] = m_mode ? INST_EXEC : INST_LOAD;
      end
      if (accept) fifo.push_back(bus.in);
      m_done = 0;
      case (ph)
         PH_IDLE: if (bus.cmd_valid) begin
            m_mode = bus.cmd_mode;
            if (bus.cmd_len > 0) begin ph = PH_RUN; m_left = int'(bus.cmd_len); end
            else begin ph = PH_DRAIN; m_drain = ROW - 1; end
         end
         PH_RUN: if (pop) begin
            m_left--;
            if (m_left == 0) begin ph = PH_DRAIN; m_drain = ROW - 1; end
         end
         PH_DRAIN: begin
            m_drain--;
            if (m_drain == 0) begin ph = PH_IDLE; m_done = 1; end
         end
         default: ;
      endcase
      @(posedge clk);
      #1;
      cyc++;
      // Row r now shows what was issued in cycle (cyc - 1 - r).
      for (int r = 0; r < ROW; r++) begin
         c = cyc - 1 - r;
         hd = '0;
         hi = '0;
         if (hist_data.exists(c)) begin hd = hist_data[c]; hi = hist_inst[c]; end
         eo[r*BW +: BW] = hd[r*BW +: BW];
         ei[2*r +: 2] = hi;
      end
      check("out_w", bus.out_w, eo);
      check("inst_w", bus.inst_w, ei);
      check("full", bus.full, fifo.size() == DEPTH);
      check("empty", bus.empty, fifo.size() == 0);
      check("wr_drop", bus.wr_drop, m_drop);
      check("busy", bus.busy, ph != PH_IDLE);
      check("cmd_ready", bus.cmd_ready, ph == PH_IDLE);
      check("done", bus.done, m_done);
      if (bus.done === 1'b1) done_hits++;
      if (bus.inst_w[1:0] === INST_LOAD) load_hits++;
   endtask

   function automatic logic [W-1:0] mk_vec(input int k);
      logic [W-1:0] v;
      for (int r = 0; r < ROW; r++) v[r*BW +: BW] = BW'(4 * k + r);
      return v;
   endfunction

   task automatic write_vec(input logic [W-1:0] v);
      bus.wr = 1'b1;
      bus.in = v;
      tick();
      bus.wr = 1'b0;
   endtask

   task automatic command(input logic mode, input int len);
      bus.cmd_valid = 1'b1;
      bus.cmd_mode = mode;
      bus.cmd_len = LEN_BW'(len);
      tick();
      bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_ready(input int budget);
      int n = 0;
      while (bus.cmd_ready !== 1'b1 && n < budget) begin tick(); n++; end
      check("wait_ready_timeout", bus.cmd_ready, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.wr = 0; bus.in = '0; bus.cmd_valid = 0; bus.cmd_mode = 0; bus.cmd_len = '0;

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_w", bus.out_w, 0);
      check("rst_inst_w", bus.inst_w, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_ready", bus.cmd_ready, 1);
      check("rst_empty", bus.empty, 1);
      check("rst_full", bus.full, 0);
      check("rst_drop", bus.wr_drop, 0);
      check("rst_done", bus.done, 0);
      #4 reset = 1'b0;
      repeat (2) tick();

      // Basic execute burst of four vectors.
      for (int k = 0; k < 4; k++) write_vec(mk_vec(k));
      done_hits = 0;
      command(1'b1, 4);
      wait_ready(40);
      repeat (2) tick();
      check("t1_done_once", done_hits, 1);

      // Overflow: depth+2 writes without a command, then drain 64.
      for (int k = 0; k < DEPTH + 2; k++) begin
         write_vec(mk_vec(100 + k));
         if (k == DEPTH - 1) check("t2_full_at_64", bus.full, 1);
         if (k == DEPTH - 1) check("t2_nodrop_at_64", bus.wr_drop, 0);
         if (k == DEPTH) check("t2_drop_at_65", bus.wr_drop, 1);
      end
      command(1'b1, DEPTH);
      wait_ready(200);
      check("t2_empty_after", bus.empty, 1);

      // Underrun: bubbles fill the gap until late vectors arrive.
      write_vec(mk_vec(20));
      write_vec(mk_vec(21));
      command(1'b1, 4);
      repeat (2) tick();
      write_vec(mk_vec(22));
      write_vec(mk_vec(23));
      wait_ready(40);

      // Kernel load of one vector with cmd_valid held while busy.
      write_vec(mk_vec(30));
      write_vec(mk_vec(31));
      load_hits = 0;
      bus.cmd_valid = 1'b1; bus.cmd_mode = 1'b0; bus.cmd_len = LEN_BW'(1);
      repeat (9) tick();
      bus.cmd_valid = 1'b0;
      wait_ready(40);
      repeat (8) tick();
      check("t4_one_load", load_hits, 1);

      // Asynchronous reset in the middle of a burst.
      for (int k = 0; k < 5; k++) write_vec(mk_vec(40 + k));
      command(1'b1, 5);
      repeat (2) tick();
      #1 reset = 1'b1;
      #1;
      check("arst_out_w", bus.out_w, 0);
      check("arst_inst_w", bus.inst_w, 0);
      check("arst_busy", bus.busy, 0);
      check("arst_done", bus.done, 0);
      check("arst_empty", bus.empty, 1);
      #2 reset = 1'b0;
      model_reset();
      write_vec(mk_vec(50));
      write_vec(mk_vec(51));
      command(1'b1, 2);
      wait_ready(40);
      check("arst_empty_after", bus.empty, 1);

      // Pointer wrap with distinct random vectors.
      for (int rnd = 0; rnd < 3; rnd++) begin
         for (int k = 0; k < 40; k++) write_vec(W'($urandom));
         command(rnd[0], 40);
         wait_ready(120);
      end

      // Random mix of writes and commands.
      repeat (400) begin
         bus.wr = ($urandom_range(0, 1) == 1);
         bus.in = W'($urandom);
         bus.cmd_valid = ($urandom_range(0, 7) == 0);
         bus.cmd_mode = $urandom_range(0, 1);
         bus.cmd_len = LEN_BW'($urandom_range(0, 6));
         tick();
      end
      bus.wr = 0; bus.cmd_valid = 0;
      wait_ready(200);
      repeat (2) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
